// File: rtl/adder_err_monitor.sv
// Error monitor for approximate adders: takes (a, b, po) samples over valid/ready,
// computes |a+b - po| in a 2-stage pipeline and accumulates error metrics per run.
module adder_err_monitor #(
  parameter int W         = 6,
  parameter int N_SAMPLES = 100,
  parameter int CNT_W     = 8,
  parameter int ACC_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_po,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [W:0]       max_abs_err,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] N_CNT  = CNT_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic             accept;
  logic             run_entry;
  logic             last_accept;
  logic [W:0]       exact;
  logic [W:0]       abs_err;
  logic [ACC_W:0]   sum_wide;

  logic             s1_valid_q, s1_valid_d;
  logic [W:0]       s1_abs_q, s1_abs_d;
  logic             s2_valid_q, s2_valid_d;
  logic [W:0]       s2_abs_q, s2_abs_d;

  logic [CNT_W-1:0] sample_count_q, sample_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [W:0]       max_q, max_d;
  logic             overflow_q, overflow_d;

  assign accept      = in_valid && in_ready;
  assign run_entry   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_accept = accept && (sample_count_q == N_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_accept) state_d = S_DRAIN;
      // Leave DRAIN on the edge that empties the last stage, so DONE and
      // the final accumulator update land together.
      S_DRAIN: if (!s1_valid_d && !s2_valid_d) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = (state_q == S_RUN) && (sample_count_q < N_CNT);
    busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    done     = (state_q == S_DONE);
  end

  // Datapath: S1 error magnitude, S2 staging, accumulators
  always_comb begin
    exact   = {1'b0, in_a} + {1'b0, in_b};
    abs_err = (exact >= in_po) ? (exact - in_po) : (in_po - exact);

    s1_valid_d = accept;
    s1_abs_d   = accept ? abs_err : s1_abs_q;
    s2_valid_d = s1_valid_q;
    s2_abs_d   = s1_abs_q;

    sum_wide = {1'b0, sum_q} + (ACC_W + 1)'(s2_abs_q);

    sample_count_d = sample_count_q;
    err_count_d    = err_count_q;
    sum_d          = sum_q;
    max_d          = max_q;
    overflow_d     = overflow_q;

    if (run_entry) begin
      sample_count_d = '0;
      err_count_d    = '0;
      sum_d          = '0;
      max_d          = '0;
      overflow_d     = 1'b0;
    end else begin
      if (accept) sample_count_d = sample_count_q + CNT_W'(1);
      if (s2_valid_q) begin
        if (s2_abs_q != '0) err_count_d = err_count_q + CNT_W'(1);
        if (sum_wide[ACC_W]) begin
          sum_d      = '1;
          overflow_d = 1'b1;
        end else begin
          sum_d = sum_wide[ACC_W-1:0];
        end
        if (s2_abs_q > max_q) max_d = s2_abs_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s1_abs_q       <= '0;
      s2_valid_q     <= 1'b0;
      s2_abs_q       <= '0;
      sample_count_q <= '0;
      err_count_q    <= '0;
      sum_q          <= '0;
      max_q          <= '0;
      overflow_q     <= 1'b0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_abs_q       <= s1_abs_d;
      s2_valid_q     <= s2_valid_d;
      s2_abs_q       <= s2_abs_d;
      sample_count_q <= sample_count_d;
      err_count_q    <= err_count_d;
      sum_q          <= sum_d;
      max_q          <= max_d;
      overflow_q     <= overflow_d;
    end
  end

  assign sample_count = sample_count_q;
  assign err_count    = err_count_q;
  assign sum_abs_err  = sum_q;
  assign max_abs_err  = max_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_adder_err_monitor.sv
// Bench for adder_err_monitor: directed scenarios plus randomized runs checked
// against a sample-list reference model (metrics recomputed from accepted samples).
module tb_adder_err_monitor;

  localparam int W     = 6;
  localparam int N     = 4;
  localparam int CNT_W = 8;
  localparam int ACC_W = 8;
  localparam int SAT   = 2 ** ACC_W - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [W:0]       in_po;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] err_count;
  logic [ACC_W-1:0] sum_abs_err;
  logic [W:0]       max_abs_err;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  adder_err_monitor #(
    .W(W), .N_SAMPLES(N), .CNT_W(CNT_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_po(in_po), .busy(busy), .done(done),
    .sample_count(sample_count), .err_count(err_count), .sum_abs_err(sum_abs_err),
    .max_abs_err(max_abs_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: run bookkeeping plus the list of accepted samples and their edge index
  int cyc = 0;
  bit m_run = 1'b0;
  int m_hs = 0;
  int m_last = 0;
  int q_cyc[$];
  int q_err[$];

  function automatic bit m_done();
    return m_run && (m_hs == N) && (cyc >= m_last + 2);
  endfunction

  function automatic bit m_ready();
    return m_run && (m_hs < N);
  endfunction

  function automatic int absdiff(input int a, input int b, input int po);
    int e;
    e = a + b - po;
    return (e < 0) ? -e : e;
  endfunction

  // Metrics visible now: samples accepted at least two edges ago
  task automatic m_metrics(output int ec, output int sum, output int mx, output bit ov);
    ec = 0; sum = 0; mx = 0; ov = 1'b0;
    foreach (q_err[i]) begin
      if (q_cyc[i] <= cyc - 2) begin
        if (q_err[i] != 0) ec++;
        sum += q_err[i];
        if (q_err[i] > mx) mx = q_err[i];
      end
    end
    if (sum > SAT) begin
      sum = SAT;
      ov  = 1'b1;
    end
  endtask

  task automatic step(input bit st, input bit v, input int a, input int b, input int po);
    bit hs;
    bit go;
    start    = st;
    in_valid = v;
    in_a     = a[W-1:0];
    in_b     = b[W-1:0];
    in_po    = po[W:0];
    hs = v && m_ready();
    go = st && !(m_run && !m_done());
    @(posedge clk);
    cyc++;
    if (go) begin
      m_run = 1'b1;
      m_hs  = 0;
      q_cyc.delete();
      q_err.delete();
    end else if (hs) begin
      m_hs++;
      q_cyc.push_back(cyc);
      q_err.push_back(absdiff(a, b, po));
      if (m_hs == N) m_last = cyc;
    end
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    cyc++;
    m_run = 1'b0;
    m_hs  = 0;
    q_cyc.delete();
    q_err.delete();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, busy, done, overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {in_ready, busy, done, overflow});
    end
    checks++;
    if ({sample_count, err_count, sum_abs_err, max_abs_err} !== '0) begin
      errors++;
      $display("FAIL reset_counters: got cnt=%0d err=%0d sum=%0d max=%0d expected all 0",
               sample_count, err_count, sum_abs_err, max_abs_err);
    end
  endtask

  task automatic test_exact();
    step(1, 1, 4, 5, 9);
    checks++;
    if (sample_count !== 8'd0 || in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_no_accept: got cnt=%0d ready=%b busy=%b expected 0 1 1",
               sample_count, in_ready, busy);
    end
    step(0, 1, 4, 5, 9);
    step(0, 1, 63, 63, 126);
    step(0, 1, 0, 0, 0);
    step(0, 1, 31, 1, 32);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL exact_drain_entry: got ready=%b busy=%b done=%b expected 0 1 0",
               in_ready, busy, done);
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL exact_drain_len: got done=%b expected 0", done);
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL exact_done: got done=%b busy=%b expected 1 0", done, busy);
    end
    checks++;
    if (sample_count !== 8'd4 || err_count !== 8'd0 || sum_abs_err !== 8'd0 || max_abs_err !== 7'd0) begin
      errors++;
      $display("FAIL exact_metrics: got cnt=%0d err=%0d sum=%0d max=%0d expected 4 0 0 0",
               sample_count, err_count, sum_abs_err, max_abs_err);
    end
  endtask

  task automatic test_errors();
    step(1, 0, 0, 0, 0);
    step(0, 1, 63, 63, 0);
    step(0, 1, 10, 10, 22);
    step(0, 1, 1, 2, 3);
    step(0, 1, 5, 6, 11);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if (done !== 1'b1 || err_count !== 8'd2 || sum_abs_err !== 8'd128 ||
        max_abs_err !== 7'd126 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL errors_metrics: got done=%b err=%0d sum=%0d max=%0d ovf=%b expected 1 2 128 126 0",
               done, err_count, sum_abs_err, max_abs_err, overflow);
    end
  endtask

  task automatic test_saturation();
    step(1, 0, 0, 0, 0);
    checks++;
    if (err_count !== 8'd0 || sum_abs_err !== 8'd0 || max_abs_err !== 7'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: got err=%0d sum=%0d max=%0d done=%b expected 0 0 0 0",
               err_count, sum_abs_err, max_abs_err, done);
    end
    for (int i = 0; i < N; i++) step(0, 1, 63, 63, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if (sum_abs_err !== 8'hFF || overflow !== 1'b1 || err_count !== 8'd4 || max_abs_err !== 7'd126) begin
      errors++;
      $display("FAIL saturation: got sum=%0d ovf=%b err=%0d max=%0d expected 255 1 4 126",
               sum_abs_err, overflow, err_count, max_abs_err);
    end
  endtask

  task automatic test_restart();
    step(1, 0, 0, 0, 0);
    checks++;
    if (sum_abs_err !== 8'd0 || overflow !== 1'b0 || done !== 1'b0 || sample_count !== 8'd0) begin
      errors++;
      $display("FAIL restart_ovf_clear: got sum=%0d ovf=%b done=%b cnt=%0d expected 0 0 0 0",
               sum_abs_err, overflow, done, sample_count);
    end
    step(0, 1, 20, 30, 50);
    step(0, 1, 7, 8, 12);
    step(0, 1, 0, 63, 63);
    step(0, 1, 33, 33, 66);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if (done !== 1'b1 || err_count !== 8'd1 || sum_abs_err !== 8'd3 ||
        max_abs_err !== 7'd3 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL restart_second_run: got done=%b err=%0d sum=%0d max=%0d ovf=%b expected 1 1 3 3 0",
               done, err_count, sum_abs_err, max_abs_err, overflow);
    end
  endtask

  task automatic test_back_to_back_bubbles();
    bit pat[6] = '{1, 0, 1, 1, 0, 1};
    int ec, sum, mx;
    bit ov;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (in_ready !== m_ready()) begin
        errors++;
        $display("FAIL bubble_ready[%0d]: got %b expected %b", i, in_ready, m_ready());
      end
      step(0, pat[i], i * 9, i * 5, i * 3);
    end
    checks++;
    if (in_ready !== 1'b0 || sample_count !== 8'd4) begin
      errors++;
      $display("FAIL bubble_count: got ready=%b cnt=%0d expected 0 4", in_ready, sample_count);
    end
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0);
    m_metrics(ec, sum, mx, ov);
    checks++;
    if (sample_count !== 8'd4 || done !== 1'b1 || err_count !== CNT_W'(ec) ||
        sum_abs_err !== ACC_W'(sum) || max_abs_err !== 7'(mx)) begin
      errors++;
      $display("FAIL bubble_metrics: got cnt=%0d done=%b err=%0d sum=%0d max=%0d expected 4 1 %0d %0d %0d",
               sample_count, done, err_count, sum_abs_err, max_abs_err, ec, sum, mx);
    end
  endtask

  task automatic test_reset_mid_run();
    step(1, 0, 0, 0, 0);
    step(0, 1, 63, 63, 1);
    step(0, 1, 2, 3, 9);
    do_reset();
    checks++;
    if ({in_ready, busy, done, overflow} !== 4'b0000 ||
        {sample_count, err_count, sum_abs_err, max_abs_err} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got rdy=%b busy=%b done=%b ovf=%b cnt=%0d err=%0d sum=%0d max=%0d expected all 0",
               in_ready, busy, done, overflow, sample_count, err_count, sum_abs_err, max_abs_err);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if (err_count !== 8'd0 || sum_abs_err !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_flush: got err=%0d sum=%0d busy=%b expected 0 0 0",
               err_count, sum_abs_err, busy);
    end
  endtask

  task automatic test_random();
    int ec, sum, mx;
    bit ov;
    int a, b, po;
    for (int run = 0; run < 4; run++) begin
      step(1, 0, 0, 0, 0);
      for (int c = 0; c < 40; c++) begin
        a  = $urandom_range(0, 63);
        b  = $urandom_range(0, 63);
        po = a + b;
        if ($urandom_range(0, 2) != 0) po = $urandom_range(0, 127);
        checks++;
        if (in_ready !== m_ready()) begin
          errors++;
          $display("FAIL rand_ready: run %0d cyc %0d got %b expected %b", run, c, in_ready, m_ready());
        end
        step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, a, b, po);
        m_metrics(ec, sum, mx, ov);
        checks++;
        if (done !== m_done() || busy !== (m_run && !m_done()) || sample_count !== CNT_W'(m_hs) ||
            err_count !== CNT_W'(ec) || sum_abs_err !== ACC_W'(sum) ||
            max_abs_err !== 7'(mx) || overflow !== ov) begin
          errors++;
          $display("FAIL rand_state: run %0d cyc %0d got done=%b busy=%b cnt=%0d err=%0d sum=%0d max=%0d ovf=%b expected %b %b %0d %0d %0d %0d %b",
                   run, c, done, busy, sample_count, err_count, sum_abs_err, max_abs_err, overflow,
                   m_done(), m_run && !m_done(), m_hs, ec, sum, mx, ov);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_po = '0;
    test_reset();
    test_exact();
    test_errors();
    test_saturation();
    test_restart();
    test_back_to_back_bubbles();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
